traffic_light_monitor: RTL and testbench

Safety monitor and lamp driver on the output side of the two-approach traffic controller. It registers the 2-bit light codes from the controller and decodes them into discrete per-lamp drives. It checks every transition against the legal sequence and dwell limits. On any violation it latches a fault and forces both approaches into flashing red until a qualified clear.

---
 rtl/traffic_light_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Lamp driver and safety monitor for a two-approach traffic controller.
// Define LIGHT_MON_STATS_EN to add the saturating preempt_count output.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_INIT  | first cycle after reset/clear, only ILLEGAL/CONFLICT
// ST_RUN   | full sequence and dwell checking every cycle
// ST_FAULT | fault latched, both approaches flash red
module traffic_light_monitor #(
  parameter int MIN_GREEN  = 25,
  parameter int MIN_YELLOW = 5,
  parameter int FLASH_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] t1_code,
  input  logic [1:0] t2_code,
  input  logic       preempt,
  input  logic       fault_clr,
  output logic       t1_red,
  output logic       t1_yellow,
  output logic       t1_green,
  output logic       t2_red,
  output logic       t2_yellow,
  output logic       t2_green,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_side
`ifdef LIGHT_MON_STATS_EN
  ,
  output logic [7:0] preempt_count
`endif
);

  localparam logic [1:0] C_RED    = 2'b00;
  localparam logic [1:0] C_GREEN  = 2'b01;
  localparam logic [1:0] C_YELLOW = 2'b10;
  localparam logic [1:0] C_ILL    = 2'b11;

  localparam logic [7:0] FLASH_RELOAD = 8'(FLASH_HALF);
  localparam logic [7:0] MIN_G8       = 8'(MIN_GREEN);
  localparam logic [7:0] MIN_Y8       = 8'(MIN_YELLOW);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;

  state_t     state, state_nx;
  logic [1:0] s1, s2, p1, p2, sv1, sv2;
  logic       sp, pp;
  logic [7:0] d1, d2;
  logic       flash;
  logic [7:0] flash_cnt;

  logic       run_chk, ill1, ill2, confl, bad1, bad2, sy1, sy2, sg1, sg2;
  logic       viol, clr_ok;
  logic [2:0] vcode;
  logic       vside;

  function automatic logic step_ok(input logic [1:0] p, input logic [1:0] s);
    return (p == s) ||
           (p == C_RED    && s == C_GREEN)  ||
           (p == C_GREEN  && s == C_YELLOW) ||
           (p == C_YELLOW && s == C_RED);
  endfunction

  // During preemption only red is allowed; on resume each side must return
  // to the code it showed just before the preempt started.
  function automatic logic bad_seq(input logic [1:0] s, input logic [1:0] p,
                                   input logic [1:0] sv, input logic sp_i,
                                   input logic pp_i);
    if (sp_i)
      return s != C_RED;
    else if (pp_i)
      return s != sv;
    else
      return !step_ok(p, s);
  endfunction

  // Dwell is frozen across a preempt and resumes counting if the side comes
  // back on its saved code, so split greens add up.
  function automatic logic [7:0] dwell_next(input logic [7:0] d, input logic [1:0] s,
                                            input logic [1:0] p, input logic [1:0] sv,
                                            input logic sp_i, input logic pp_i);
    logic same;
    same = pp_i ? (s == sv) : (s == p);
    if (sp_i)
      return d;
    else if (!same)
      return 8'd1;
    else if (d == 8'hFF)
      return d;
    else
      return d + 8'd1;
  endfunction

  always_comb begin
    run_chk = (state != ST_INIT);
    ill1    = (s1 == C_ILL);
    ill2    = (s2 == C_ILL);
    confl   = (s1 != C_RED) && (s2 != C_RED);
    bad1    = run_chk && bad_seq(s1, p1, sv1, sp, pp);
    bad2    = run_chk && bad_seq(s2, p2, sv2, sp, pp);
    sy1     = run_chk && !sp && p1 == C_YELLOW && s1 == C_RED    && d1 < MIN_Y8;
    sy2     = run_chk && !sp && p2 == C_YELLOW && s2 == C_RED    && d2 < MIN_Y8;
    sg1     = run_chk && !sp && p1 == C_GREEN  && s1 == C_YELLOW && d1 < MIN_G8;
    sg2     = run_chk && !sp && p2 == C_GREEN  && s2 == C_YELLOW && d2 < MIN_G8;

    viol  = 1'b1;
    vcode = 3'd0;
    vside = 1'b0;
    if      (ill1)  begin vcode = 3'd1; vside = 1'b0; end
    else if (ill2)  begin vcode = 3'd1; vside = 1'b1; end
    else if (confl) begin vcode = 3'd2; vside = 1'b0; end
    else if (bad1)  begin vcode = 3'd3; vside = 1'b0; end
    else if (bad2)  begin vcode = 3'd3; vside = 1'b1; end
    else if (sy1)   begin vcode = 3'd4; vside = 1'b0; end
    else if (sy2)   begin vcode = 3'd4; vside = 1'b1; end
    else if (sg1)   begin vcode = 3'd5; vside = 1'b0; end
    else if (sg2)   begin vcode = 3'd5; vside = 1'b1; end
    else            viol = 1'b0;

    clr_ok = fault_clr && s1 == C_RED && s2 == C_RED && !sp && !viol;

    state_nx = state;
    case (state)
      ST_INIT, ST_RUN: state_nx = viol ? ST_FAULT : ST_RUN;
      ST_FAULT:        if (clr_ok) state_nx = ST_INIT;
      default:         state_nx = ST_INIT;
    endcase
  end

  always_comb begin
    t1_red    = 1'b1;
    t1_yellow = 1'b0;
    t1_green  = 1'b0;
    t2_red    = 1'b1;
    t2_yellow = 1'b0;
    t2_green  = 1'b0;
    if (state == ST_FAULT) begin
      t1_red = flash;
      t2_red = flash;
    end else if (!viol && !ill1 && !ill2) begin
      t1_red    = (s1 == C_RED);
      t1_yellow = (s1 == C_YELLOW);
      t1_green  = (s1 == C_GREEN);
      t2_red    = (s2 == C_RED);
      t2_yellow = (s2 == C_YELLOW);
      t2_green  = (s2 == C_GREEN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      s1         <= C_RED;
      s2         <= C_RED;
      p1         <= C_RED;
      p2         <= C_RED;
      sv1        <= C_RED;
      sv2        <= C_RED;
      sp         <= 1'b0;
      pp         <= 1'b0;
      d1         <= 8'd0;
      d2         <= 8'd0;
      flash      <= 1'b1;
      flash_cnt  <= FLASH_RELOAD;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      fault_side <= 1'b0;
    end else begin
      s1    <= t1_code;
      s2    <= t2_code;
      sp    <= preempt;
      p1    <= s1;
      p2    <= s2;
      pp    <= sp;
      state <= state_nx;
      d1    <= dwell_next(d1, s1, p1, sv1, sp, pp);
      d2    <= dwell_next(d2, s2, p2, sv2, sp, pp);
      if (sp && !pp) begin
        sv1 <= p1;
        sv2 <= p2;
      end
      if (state != ST_FAULT && viol) begin
        fault      <= 1'b1;
        fault_code <= vcode;
        fault_side <= vside;
        flash      <= 1'b1;
        flash_cnt  <= FLASH_RELOAD;
      end else if (state == ST_FAULT) begin
        if (clr_ok) begin
          fault      <= 1'b0;
          fault_code <= 3'd0;
          fault_side <= 1'b0;
        end
        if (flash_cnt <= 8'd1) begin
          flash     <= ~flash;
          flash_cnt <= FLASH_RELOAD;
        end else begin
          flash_cnt <= flash_cnt - 8'd1;
        end
      end
    end
  end

`ifdef LIGHT_MON_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      preempt_count <= 8'd0;
    else if (sp && !pp && preempt_count != 8'hFF)
      preempt_count <= preempt_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: history-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_traffic_light_monitor;
  localparam int MIN_GREEN  = 25;
  localparam int MIN_YELLOW = 5;
  localparam int FLASH_HALF = 1;
  localparam logic [1:0] R = 2'b00, G = 2'b01, Y = 2'b10, X = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] t1_code = R, t2_code = R;
  logic       preempt = 1'b0, fault_clr = 1'b0;
  logic       t1_red, t1_yellow, t1_green, t2_red, t2_yellow, t2_green;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_side;
`ifdef LIGHT_MON_STATS_EN
  logic [7:0] preempt_count;
`endif

  int checks = 0;
  int failures = 0;

  traffic_light_monitor #(.MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW),
                          .FLASH_HALF(FLASH_HALF)) dut (
    .clk(clk), .rst(rst), .t1_code(t1_code), .t2_code(t2_code),
    .preempt(preempt), .fault_clr(fault_clr),
    .t1_red(t1_red), .t1_yellow(t1_yellow), .t1_green(t1_green),
    .t2_red(t2_red), .t2_yellow(t2_yellow), .t2_green(t2_green),
    .fault(fault), .fault_code(fault_code), .fault_side(fault_side)
`ifdef LIGHT_MON_STATS_EN
    , .preempt_count(preempt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: full sample history since reset
  logic [1:0] h1[$], h2[$];
  bit         hp[$];
  logic [1:0] ms1 = R, ms2 = R, mp1 = R, mp2 = R;
  bit         msp = 0, mpp = 0;
  bit         m_fault = 0, m_init = 1, ev = 0;
  int         m_code = 0, m_side = 0, m_age = 0, ec = 0, es = 0;

  function automatic bit legal(input logic [1:0] p, input logic [1:0] s);
    return (p == s) || (p == R && s == G) || (p == G && s == Y) || (p == Y && s == R);
  endfunction

  function automatic logic [1:0] code_at(input int side, input int idx);
    return side != 0 ? h2[idx] : h1[idx];
  endfunction

  // samples of the previous code, walking back and ignoring preempt samples
  function automatic int dwell_of(input int side);
    int idx, cnt;
    logic [1:0] c;
    idx = h1.size() - 2;
    cnt = 0;
    if (idx < 0) return 0;
    c = code_at(side, idx);
    for (int j = idx; j >= 0; j--) begin
      if (hp[j]) continue;
      if (code_at(side, j) != c) break;
      cnt++;
    end
    return (cnt > 255) ? 255 : cnt;
  endfunction

  function automatic logic [1:0] saved_of(input int side);
    int idx;
    idx = h1.size() - 2;
    while (idx >= 0 && hp[idx]) idx--;
    return (idx < 0) ? R : code_at(side, idx);
  endfunction

  task automatic evaluate();
    bit flag [1:5][0:1];
    logic [1:0] s, p;
    for (int c = 1; c <= 5; c++)
      for (int i = 0; i < 2; i++) flag[c][i] = 0;
    for (int i = 0; i < 2; i++) begin
      s = (i != 0) ? ms2 : ms1;
      p = (i != 0) ? mp2 : mp1;
      flag[1][i] = (s == X);
      if (!m_init) begin
        if (msp)      flag[3][i] = (s != R);
        else if (mpp) flag[3][i] = (s != saved_of(i));
        else          flag[3][i] = !legal(p, s);
        flag[4][i] = !msp && p == Y && s == R && dwell_of(i) < MIN_YELLOW;
        flag[5][i] = !msp && p == G && s == Y && dwell_of(i) < MIN_GREEN;
      end
    end
    flag[2][0] = (ms1 != R) && (ms2 != R);
    ev = 0; ec = 0; es = 0;
    for (int c = 5; c >= 1; c--)
      for (int i = 1; i >= 0; i--)
        if (flag[c][i]) begin ev = 1; ec = c; es = i; end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1.delete(); h2.delete(); hp.delete();
      ms1 = R; ms2 = R; mp1 = R; mp2 = R; msp = 0; mpp = 0;
      m_fault = 0; m_init = 1; m_code = 0; m_side = 0; m_age = 0;
      ev = 0; ec = 0; es = 0;
    end else begin
      if (m_fault) begin
        if (fault_clr && ms1 == R && ms2 == R && !msp && !ev) begin
          m_fault = 0; m_code = 0; m_side = 0; m_init = 1;
        end else m_age++;
      end else if (ev) begin
        m_fault = 1; m_code = ec; m_side = es; m_age = 0; m_init = 0;
      end else m_init = 0;
      mp1 = ms1; mp2 = ms2; mpp = msp;
      ms1 = t1_code; ms2 = t2_code; msp = preempt;
      h1.push_back(t1_code); h2.push_back(t2_code); hp.push_back(preempt);
      evaluate();
    end
  end

  function automatic logic [2:0] lamp(input logic [1:0] c);
    case (c)
      R:       return 3'b100;
      Y:       return 3'b010;
      G:       return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [5:0] el;
    logic       fl;
    fl = ((m_age / FLASH_HALF) % 2) == 0;
    if (m_fault)                         el = {fl, 2'b00, fl, 2'b00};
    else if (ev || ms1 == X || ms2 == X) el = 6'b100100;
    else                                 el = {lamp(ms1), lamp(ms2)};
    chk("lamps", {t1_red, t1_yellow, t1_green, t2_red, t2_yellow, t2_green}, el);
    chk("fault_state", {fault, fault_code, fault_side}, {m_fault, 3'(m_code), m_side[0]});
  end

  // ---------------- directed stimulus
  task automatic drive(input logic [1:0] c1, input logic [1:0] c2,
                       input logic pr, input logic clr, input int n);
    t1_code = c1; t2_code = c2; preempt = pr; fault_clr = clr;
    repeat (n) @(posedge clk);
    #1;
    fault_clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lamps", {t1_red, t1_yellow, t1_green, t2_red, t2_yellow, t2_green}, 6'b100100);
    chk("rst_fault", {fault, fault_code, fault_side}, 0);
    rst = 1'b0;

    // green one cycle short of MIN_GREEN
    drive(G, R, 0, 0, 24);
    drive(Y, R, 0, 0, 1);
    chk("sg_redonly", {t1_red, t1_yellow}, 2'b10);
    drive(Y, R, 0, 0, 1);
    chk("sg_code", {fault, fault_code, fault_side}, {1'b1, 3'd5, 1'b0});
    drive(R, R, 0, 0, 2);
    drive(R, R, 0, 1, 1);
    chk("sg_clear", {fault, fault_code}, 0);
    drive(R, R, 0, 0, 1);

    // normal operation, three full periods
    for (int k = 0; k < 3; k++) begin
      drive(G, R, 0, 0, 26);
      chk("norm_green", {t1_green, t2_red}, 2'b11);
      drive(Y, R, 0, 0, 5);
      drive(R, R, 0, 0, 2);
      drive(R, G, 0, 0, 26);
      drive(R, Y, 0, 0, 5);
      drive(R, R, 0, 0, 27);
    end
    chk("norm_nofault", fault, 0);

    // approach 2 short yellow
    drive(R, G, 0, 0, 30);
    drive(R, Y, 0, 0, 3);
    drive(R, R, 0, 0, 1);
    chk("sy_redonly", {t2_red, t2_yellow, fault}, 3'b100);
    drive(R, R, 0, 0, 1);
    chk("sy_code", {fault, fault_code, fault_side, t2_red}, {1'b1, 3'd4, 1'b1, 1'b1});
    drive(R, R, 0, 0, 1);
    chk("sy_flash_off", {t1_red, t2_red}, 2'b00);
    drive(R, R, 0, 1, 1);
    chk("sy_clear", fault, 0);
    drive(R, R, 0, 0, 1);

    // conflict, flashing, and clear qualification
    drive(G, R, 0, 0, 10);
    drive(G, G, 0, 0, 1);
    chk("cf_redonly", {t1_red, t1_green, t2_red, t2_green, fault}, 5'b10100);
    drive(G, G, 0, 0, 1);
    chk("cf_code", {fault, fault_code, fault_side, t1_red}, {1'b1, 3'd2, 1'b0, 1'b1});
    drive(G, G, 0, 0, 1);
    chk("cf_flash0", t1_red, 0);
    drive(G, G, 0, 0, 1);
    chk("cf_flash1", t2_red, 1);
    drive(G, R, 0, 1, 1);
    drive(R, R, 0, 1, 1);
    drive(R, R, 0, 1, 1);
    chk("cf_clr_ignored", {fault, fault_code}, {1'b1, 3'd2});
    drive(R, R, 0, 0, 1);
    drive(R, R, 0, 1, 1);
    chk("cf_clear", {fault, fault_code, fault_side}, 0);
    drive(R, R, 0, 0, 1);

    // preemption splits a green 10 + 15 = MIN_GREEN
    drive(G, R, 0, 0, 10);
    drive(R, R, 1, 0, 10);
    drive(G, R, 0, 0, 15);
    chk("pre_resume_green", t1_green, 1);
    drive(Y, R, 0, 0, 5);
    drive(R, R, 0, 0, 2);
    chk("pre_nofault", fault, 0);

    // resuming on a different code
    drive(G, R, 0, 0, 30);
    drive(R, R, 1, 0, 5);
    drive(Y, R, 0, 0, 1);
    chk("pre_bad_redonly", {t1_red, t1_yellow}, 2'b10);
    drive(Y, R, 0, 0, 1);
    chk("pre_bad_code", {fault, fault_code, fault_side}, {1'b1, 3'd3, 1'b0});
    drive(R, R, 0, 0, 3);
    drive(R, R, 0, 1, 1);
    chk("pre_bad_clear", fault, 0);
    drive(R, R, 0, 0, 1);

    // illegal code, clear blocked while preempt active
    drive(R, X, 0, 0, 1);
    chk("ill_redonly", {t2_red, t2_yellow, t2_green, fault}, 4'b1000);
    drive(R, X, 0, 0, 1);
    chk("ill_code", {fault, fault_code, fault_side}, {1'b1, 3'd1, 1'b1});
    drive(R, R, 1, 0, 2);
    drive(R, R, 1, 1, 1);
    chk("ill_clr_preempt", fault, 1);
    drive(R, R, 0, 0, 3);
    drive(R, R, 0, 1, 1);
    chk("ill_clear", fault, 0);
`ifdef LIGHT_MON_STATS_EN
    chk("preempt_count", preempt_count, 3);
`endif
    drive(R, R, 0, 0, 1);

    // reset in the middle of flashing
    drive(G, R, 0, 0, 5);
    drive(G, G, 0, 0, 4);
    chk("rf_in_fault", fault, 1);
    rst = 1'b1;
    #1;
    chk("rf_lamps", {t1_red, t1_yellow, t1_green, t2_red, t2_yellow, t2_green}, 6'b100100);
    chk("rf_fault", {fault, fault_code, fault_side}, 0);
`ifdef LIGHT_MON_STATS_EN
    chk("rf_count", preempt_count, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(R, R, 0, 0, 3);
    chk("rf_after", {t1_red, t2_red, fault}, 3'b110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
